// File: rtl/fabric_cfg_pkg.sv
// Shared types and helpers for the fabric configuration scan-chain loader.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        FINISH
    } cfg_state_e;

    localparam int CFG_WORD_W_DEFAULT = 8;

    // Host words needed to fill a chain of chain_len bits.
    function automatic int cfg_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/fabric_cfg_loader_scan_serializer.sv
// WORD_W shift register used for both transmit (parallel in, MSB out) and
// readback capture (serial in, parallel out).
module scan_serializer #(
    parameter int WORD_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         load_i,
    input  logic                         shift_i,
    input  logic [WORD_W-1:0]            data_i,
    input  logic                         serial_i,
    output logic                         msb_o,
    output logic                         empty_o,
    output logic [WORD_W-1:0]            nxt_data_o,
    output logic [$clog2(WORD_W+1)-1:0]  nxt_cnt_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  word_bit_q, word_bit_d;

    // load together with shift consumes the loaded MSB in the same cycle
    always_comb begin
        data_d     = data_q;
        word_bit_d = word_bit_q;
        if (load_i && shift_i) begin
            data_d     = (data_i << 1) | WORD_W'(serial_i);
            word_bit_d = CNT_W'(WORD_W - 1);
        end else if (load_i) begin
            data_d     = data_i;
            word_bit_d = CNT_W'(WORD_W);
        end else if (shift_i) begin
            data_d = (data_q << 1) | WORD_W'(serial_i);
            if (word_bit_q != '0) begin
                word_bit_d = word_bit_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q     <= '0;
            word_bit_q <= '0;
        end else begin
            data_q     <= data_d;
            word_bit_q <= word_bit_d;
        end
    end

    assign msb_o      = data_q[WORD_W-1];
    assign empty_o    = (word_bit_q == '0);
    assign nxt_data_o = data_d;
    assign nxt_cnt_o  = word_bit_d;

endmodule

// File: rtl/fabric_cfg_loader.sv
// Routing-channel configuration loader: host words in, MSB-first scan stream out.
// Define CFG_READBACK_EN to capture the old chain content from scan_out.
module fabric_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = CFG_WORD_W_DEFAULT
) (
    input  logic              scan_clk,
    input  logic              scan_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data
);

    localparam int BC_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CHAIN_LEN);

    cfg_state_e      state_q;
    logic [BC_W-1:0] bit_cnt_q;
    logic            scan_en_q, scan_in_q, busy_q, done_q;

    logic            handshake, last_bit, tx_shift, tx_msb, tx_empty;
    logic [WORD_W-1:0] tx_nxt_data_unused;
    logic [WB_W-1:0]   tx_nxt_cnt_unused;

    // bit_cnt_q counts bits presented so far, including the one on scan_in
    assign last_bit = (bit_cnt_q == LAST_BIT);

    always_comb begin
        cfg_ready = 1'b0;
        if (!abort) begin
            case (state_q)
                FETCH:   cfg_ready = 1'b1;
                SHIFT:   cfg_ready = tx_empty && !last_bit;
                default: cfg_ready = 1'b0;
            endcase
        end
    end

    assign handshake = cfg_valid && cfg_ready;
    assign tx_shift  = handshake ||
                       ((state_q == SHIFT) && !abort && !last_bit && !tx_empty);

    scan_serializer #(.WORD_W(WORD_W)) u_tx (
        .clk_i      (scan_clk),
        .rst_n_i    (scan_rst_n),
        .load_i     (handshake),
        .shift_i    (tx_shift),
        .data_i     (cfg_data),
        .serial_i   (1'b0),
        .msb_o      (tx_msb),
        .empty_o    (tx_empty),
        .nxt_data_o (tx_nxt_data_unused),
        .nxt_cnt_o  (tx_nxt_cnt_unused)
    );

    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                scan_en_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= FETCH;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    FETCH: begin
                        if (handshake) begin
                            state_q   <= SHIFT;
                            scan_en_q <= 1'b1;
                            scan_in_q <= cfg_data[WORD_W-1];
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            state_q   <= FINISH;
                            scan_en_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (!tx_empty) begin
                            scan_in_q <= tx_msb;
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end else if (handshake) begin
                            scan_in_q <= cfg_data[WORD_W-1];
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end else begin
                            state_q   <= FETCH;
                            scan_en_q <= 1'b0;
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign scan_en = scan_en_q;
    assign scan_in = scan_in_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef CFG_READBACK_EN
    logic              rx_first_q, rd_valid_q;
    logic [WORD_W-1:0] rd_data_q, rx_nxt_data;
    logic [WB_W-1:0]   rx_nxt_cnt;
    logic              rx_msb_unused, rx_empty_unused;

    scan_serializer #(.WORD_W(WORD_W)) u_rx (
        .clk_i      (scan_clk),
        .rst_n_i    (scan_rst_n),
        .load_i     (rx_first_q && scan_en_q),
        .shift_i    (scan_en_q),
        .data_i     ('0),
        .serial_i   (scan_out),
        .msb_o      (rx_msb_unused),
        .empty_o    (rx_empty_unused),
        .nxt_data_o (rx_nxt_data),
        .nxt_cnt_o  (rx_nxt_cnt)
    );

    // shifting left by the unfilled count left-aligns a short final word
    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            rx_first_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (abort) begin
                rx_first_q <= 1'b1;
            end else if (scan_en_q) begin
                if ((rx_nxt_cnt == '0) || last_bit) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= rx_nxt_data << rx_nxt_cnt;
                    rx_first_q <= 1'b1;
                end else begin
                    rx_first_q <= 1'b0;
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    logic unused_scan_out;
    assign unused_scan_out = scan_out;
    assign rd_valid        = 1'b0;
    assign rd_data         = '0;
`endif

endmodule
